seg7_sequence_monitor: RTL

Receive-side checker for the 7-segment display path. Each strobed cycle it samples an 8-bit segment pattern and decodes it back to a 4-bit hex value using the inverse of the board's segment table. It then tracks the value sequence against the bouncing up/down counter rule (0→15 up, 15→0 down, turning at the ends). It drives decoded value, direction, lock and error status to LEDs/LCD debug registers, closing the loop on the display encoder.

---
 rtl/seg7_pkg.sv | 19 +
 rtl/seg7_decode.sv | 23 ++
 rtl/seg7_sequence_monitor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display encoder and the receive-side monitor.
// Segment bits are {dp, g, f, e, d, c, b, a}, active-high.
package seg7_pkg;

    localparam logic [7:0] SEG_TABLE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    localparam logic [7:0] SEG_DP_ONLY = 8'h80;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAcquire = 2'd1,
        StTrack   = 2'd2,
        StLocked  = 2'd3
    } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Inverse segment table: exact match of the full pattern against the 16 hex glyphs.
module seg7_decode
    import seg7_pkg::*;
#(
    parameter int unsigned NBITS_SEG = 8
) (
    input  logic [NBITS_SEG-1:0] pattern,
    output logic                 valid,
    output logic [3:0]           hex
);

    always_comb begin
        valid = 1'b0;
        hex   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == NBITS_SEG'(SEG_TABLE[i])) begin
                valid = 1'b1;
                hex   = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_sequence_monitor.sv
// Decodes sampled segment patterns and checks them against the bouncing 0..15..0 counter rule.
// All status outputs are registered and respond one cycle after the sampling edge.
module seg7_sequence_monitor
    import seg7_pkg::*;
#(
    parameter int unsigned NBITS_SEG = 8,
    parameter int unsigned LOCK_LEN  = 4,
    parameter int unsigned NBITS_ERR = 8
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic                 sample,
    input  logic [NBITS_SEG-1:0] seg_in,
    output logic [3:0]           value,
    output logic                 value_valid,
    output logic                 bad_pattern,
    output logic                 mismatch,
    output logic                 direction,
    output logic                 locked,
    output logic [NBITS_ERR-1:0] err_count,
    output logic [1:0]           state
);

    localparam logic [4:0] LOCK_TARGET = 5'(LOCK_LEN);

    state_t     state_q;
    logic [3:0] ref_q;
    logic [3:0] match_q;
    logic       dec_valid;
    logic [3:0] dec_value;
    logic [3:0] pred;
    logic       pred_dir;
    logic       acq_up;
    logic       acq_down;
    logic [4:0] match_next;
    logic [NBITS_ERR-1:0] err_inc;

    seg7_decode #(
        .NBITS_SEG (NBITS_SEG)
    ) u_decode (
        .pattern (seg_in),
        .valid   (dec_valid),
        .hex     (dec_value)
    );

    // Next expected value; the direction flips only when turning at an end.
    always_comb begin
        pred     = ref_q;
        pred_dir = direction;
        if (!direction) begin
            if (ref_q == 4'd15) begin
                pred     = 4'd14;
                pred_dir = 1'b1;
            end else begin
                pred = ref_q + 4'd1;
            end
        end else begin
            if (ref_q == 4'd0) begin
                pred     = 4'd1;
                pred_dir = 1'b0;
            end else begin
                pred = ref_q - 4'd1;
            end
        end
    end

    assign acq_up     = (ref_q != 4'd15) && (dec_value == ref_q + 4'd1);
    assign acq_down   = (ref_q != 4'd0) && (dec_value == ref_q - 4'd1);
    assign match_next = {1'b0, match_q} + 5'd1;
    assign err_inc    = (err_count == '1) ? err_count : err_count + NBITS_ERR'(1);
    assign state      = state_q;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q     <= StIdle;
            ref_q       <= 4'd0;
            match_q     <= 4'd0;
            value       <= 4'd0;
            value_valid <= 1'b0;
            bad_pattern <= 1'b0;
            mismatch    <= 1'b0;
            direction   <= 1'b0;
            locked      <= 1'b0;
            err_count   <= '0;
        end else begin
            value_valid <= 1'b0;
            bad_pattern <= 1'b0;
            mismatch    <= 1'b0;
            if (sample) begin
                if (!dec_valid) begin
                    bad_pattern <= 1'b1;
                    err_count   <= err_inc;
                    state_q     <= StIdle;
                    match_q     <= 4'd0;
                    locked      <= 1'b0;
                end else begin
                    value       <= dec_value;
                    value_valid <= 1'b1;
                    ref_q       <= dec_value;
                    unique case (state_q)
                        StIdle: state_q <= StAcquire;
                        StAcquire: begin
                            if (acq_up || acq_down) begin
                                direction <= acq_down;
                                match_q   <= 4'd1;
                                if (LOCK_TARGET == 5'd1) begin
                                    state_q <= StLocked;
                                    locked  <= 1'b1;
                                end else begin
                                    state_q <= StTrack;
                                end
                            end
                        end
                        StTrack, StLocked: begin
                            if (dec_value == pred) begin
                                direction <= pred_dir;
                                if (state_q == StTrack) begin
                                    match_q <= match_next[3:0];
                                    if (match_next == LOCK_TARGET) begin
                                        state_q <= StLocked;
                                        locked  <= 1'b1;
                                    end
                                end
                            end else begin
                                // Loads and repeated values both land here.
                                mismatch  <= 1'b1;
                                err_count <= err_inc;
                                state_q   <= StAcquire;
                                match_q   <= 4'd0;
                                locked    <= 1'b0;
                            end
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

endmodule
